// File: rtl/sram_arbiter_if.sv
// Requester-side handshake and SRAM pad signals shared by sram_arbiter and its users.
// slave = arbiter view, master = requester/pad view.
interface sram_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       rd_data;
  logic                    busy;
  logic [ADDR_W-1:0]       sram_addr;
  logic                    sram_ce_n;
  logic                    sram_oe_n;
  logic                    sram_we_n;
  logic [DATA_W-1:0]       sram_dq_out;
  logic                    sram_dq_oe;
  logic [DATA_W-1:0]       sram_dq_in;

  modport slave (
    input  req, req_we, req_addr, req_wdata, sram_dq_in,
    output ack, grant, rd_data, busy, sram_addr, sram_ce_n, sram_oe_n,
           sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport master (
    output req, req_we, req_addr, req_wdata, sram_dq_in,
    input  ack, grant, rd_data, busy, sram_addr, sram_ce_n, sram_oe_n,
           sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin (optional fixed-priority requester 0) arbiter for one shared single-word SRAM port.
// Ack ACCESS_CYCLES+1 cycles after the win; requesters hold req/operands until ack, nothing is aborted.
module sram_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter bit PRIO0         = 1'b0
) (
  input logic           i_clk,
  input logic           i_rst,
  sram_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] elig;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  // The requester being acked this cycle is excluded, so it cannot win back-to-back.
  always_comb begin
    elig    = bus.req & ~bus.ack;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (PRIO0 && elig[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end else begin
      for (int i = 1; i <= N_REQ; i++) begin
        cand = IDX_W'((int'(ptr) + i) % N_REQ);
        if (!win_vld && elig[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      ptr             <= IDX_W'(N_REQ - 1);
      cnt             <= '0;
      bus.ack         <= '0;
      bus.grant       <= '0;
      bus.busy        <= 1'b0;
      bus.rd_data     <= '0;
      bus.sram_addr   <= '0;
      bus.sram_dq_out <= '0;
      bus.sram_dq_oe  <= 1'b0;
      bus.sram_ce_n   <= 1'b1;
      bus.sram_oe_n   <= 1'b1;
      bus.sram_we_n   <= 1'b1;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            bus.grant       <= N_REQ'(1) << win_idx;
            bus.busy        <= 1'b1;
            bus.sram_ce_n   <= 1'b0;
            bus.sram_addr   <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            bus.sram_dq_out <= bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            bus.sram_oe_n   <= bus.req_we[win_idx];
            bus.sram_we_n   <= ~bus.req_we[win_idx];
            bus.sram_dq_oe  <= bus.req_we[win_idx];
            ptr             <= win_idx;
            cnt             <= CNT_W'(ACCESS_CYCLES - 1);
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!bus.sram_oe_n) begin
              bus.rd_data <= bus.sram_dq_in;
            end
            // Address and write data stay on the pad; only strobes and ownership drop.
            bus.ack        <= bus.grant;
            bus.grant      <= '0;
            bus.busy       <= 1'b0;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
            bus.sram_dq_oe <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: two instances (PRIO0=0 and PRIO0=1) share stimulus.
module tb_sram_arbiter;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int AC = 2;

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            gap;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  int   remaining [N];
  txn_t sbq [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_len = 0;
  int   last_ack = -1;
  logic [DW-1:0] rd_exp = '0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sram_model(input logic [AW-1:0] a);
    return (a == 20'h00123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  sram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
  sram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.req        = req;
  assign bus0.req_we     = req_we;
  assign bus0.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus0.sram_dq_in = sram_model(bus0.sram_addr);
  assign bus1.req        = req;
  assign bus1.req_we     = req_we;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus1.sram_dq_in = sram_model(bus1.sram_addr);

  sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .PRIO0(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0));
  sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .PRIO0(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1));

  logic [N-1:0]  m_ack, m_grant;
  logic [DW-1:0] m_rd, m_dqo;
  logic [AW-1:0] m_addr;
  logic          m_busy, m_ce, m_oe, m_we, m_dqoe;
  assign m_ack   = sel ? bus1.ack         : bus0.ack;
  assign m_grant = sel ? bus1.grant       : bus0.grant;
  assign m_rd    = sel ? bus1.rd_data     : bus0.rd_data;
  assign m_dqo   = sel ? bus1.sram_dq_out : bus0.sram_dq_out;
  assign m_addr  = sel ? bus1.sram_addr   : bus0.sram_addr;
  assign m_busy  = sel ? bus1.busy        : bus0.busy;
  assign m_ce    = sel ? bus1.sram_ce_n   : bus0.sram_ce_n;
  assign m_oe    = sel ? bus1.sram_oe_n   : bus0.sram_oe_n;
  assign m_we    = sel ? bus1.sram_we_n   : bus0.sram_we_n;
  assign m_dqoe  = sel ? bus1.sram_dq_oe  : bus0.sram_dq_oe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requesters drop req in the cycle of their last ack.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (m_ack[k] && remaining[k] > 0) begin
        remaining[k]--;
        if (remaining[k] == 0) req[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_op(input int k, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int n);
    req_we[k]              = we;
    req_addr[k*AW +: AW]   = a;
    req_wdata[k*DW +: DW]  = d;
    remaining[k]           = n;
  endtask

  task automatic expect_txn(input int k, input int gap);
    txn_t t;
    t.idx   = k;
    t.we    = req_we[k];
    t.addr  = req_addr[k*AW +: AW];
    t.wdata = req_wdata[k*DW +: DW];
    t.rdata = sram_model(t.addr);
    t.gap   = gap;
    sbq.push_back(t);
  endtask

  task automatic reset_on();
    rst = 1'b1;
    sbq.delete();
    req = '0;
    for (int k = 0; k < N; k++) remaining[k] = 0;
    repeat (2) step();
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0 && !m_busy && m_ack == '0) return;
      step();
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_ctl", {m_ack, m_grant, m_busy, m_dqoe, m_ce, m_oe, m_we}, {4'b0, 4'b0, 1'b0, 1'b0, 3'b111});
    chk("rst_data", {m_rd, m_dqo}, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
  endtask

  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (rst) begin
      busy_len = 0;
      last_ack = -1;
      rd_exp   = '0;
    end else begin
      if (m_busy) begin
        busy_len++;
        if (sbq.size() == 0) begin
          chk("busy_unexpected", 32'd1, 32'd0);
        end else begin
          t = sbq[0];
          chk("grant", m_grant, 32'(1) << t.idx);
          chk("sram_addr", m_addr, t.addr);
          chk("strobes", {m_ce, m_oe, m_we, m_dqoe}, {1'b0, t.we, ~t.we, t.we});
          if (t.we) chk("dq_out", m_dqo, t.wdata);
        end
      end else if (busy_len != 0) begin
        chk("access_len", busy_len, AC);
        busy_len = 0;
      end
      if (m_ack != '0) begin
        if (sbq.size() == 0) begin
          chk("ack_unexpected", m_ack, 32'd0);
        end else begin
          t = sbq.pop_front();
          chk("ack", m_ack, 32'(1) << t.idx);
          if (!t.we) rd_exp = t.rdata;
          chk("rd_data", m_rd, rd_exp);
          chk("ack_strobes", {m_ce, m_oe, m_we, m_dqoe}, 4'b1110);
          if (t.gap != 0 && last_ack >= 0) chk("ack_gap", cyc - last_ack, t.gap);
        end
        last_ack = cyc;
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) remaining[k] = 0;
    rst = 1'b1;
    repeat (3) step();
    sel = 1'b0; #1; chk_reset();
    sel = 1'b1; #1; chk_reset();
    sel = 1'b0; #1;
    rst = 1'b0;
    step();

    // single read with explicit latency check
    set_op(1, 1'b0, 20'h00123, 16'h0000, 1);
    expect_txn(1, 0);
    req[1] = 1'b1;
    repeat (3) step();
    chk("read_ack_t3", m_ack, 4'b0010);
    chk("read_data_t3", m_rd, 16'hBEEF);
    wait_quiet();

    // single write; rd_data must keep the previous read
    set_op(2, 1'b1, 20'h0ABCD, 16'h1234, 1);
    expect_txn(2, 0);
    req[2] = 1'b1;
    wait_quiet();

    // same requester back-to-back, no competition
    set_op(1, 1'b0, 20'h00200, 16'h0000, 2);
    expect_txn(1, 0);
    expect_txn(1, AC + 2);
    req[1] = 1'b1;
    wait_quiet();

    // round-robin from reset, all requesting
    reset_on();
    for (int k = 0; k < N; k++)
      set_op(k, (k % 2) == 1, AW'(20'h00040 + k * 256), DW'(16'hC000 + k), 2);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) expect_txn(k, (r == 0 && k == 0) ? 0 : AC + 1);
    req = '1;
    rst = 1'b0;
    wait_quiet();

    // fixed priority: 0 and 2 alternate
    reset_on();
    sel = 1'b1;
    set_op(0, 1'b0, 20'h00300, 16'h0000, 3);
    set_op(2, 1'b1, 20'h00302, 16'hA0A2, 3);
    for (int r = 0; r < 3; r++) begin
      expect_txn(0, (r == 0) ? 0 : AC + 1);
      expect_txn(2, AC + 1);
    end
    req[0] = 1'b1;
    req[2] = 1'b1;
    rst = 1'b0;
    wait_quiet();

    // fixed priority starves 2 while 0 and 1 are active
    reset_on();
    set_op(0, 1'b1, 20'h00400, 16'h4444, 2);
    set_op(1, 1'b0, 20'h00401, 16'h0000, 2);
    set_op(2, 1'b0, 20'h00402, 16'h0000, 1);
    expect_txn(0, 0);
    expect_txn(1, AC + 1);
    expect_txn(0, AC + 1);
    expect_txn(1, AC + 1);
    expect_txn(2, AC + 1);
    req[2:0] = 3'b111;
    rst = 1'b0;
    wait_quiet();

    // operands change and req drops during ACCESS
    reset_on();
    sel = 1'b0;
    rst = 1'b0;
    step();
    set_op(3, 1'b0, 20'h00010, 16'h0000, 1);
    expect_txn(3, 0);
    req[3] = 1'b1;
    step();
    req_addr[3*AW +: AW] = 20'h00020;
    req[3] = 1'b0;
    wait_quiet();
    repeat (4) begin
      step();
      chk("no_regrant", {m_busy, m_grant}, 32'd0);
    end

    // reset in the first ACCESS cycle of a write
    set_op(2, 1'b1, 20'h0BEE0, 16'h5555, 1);
    expect_txn(2, 0);
    req[2] = 1'b1;
    for (int i = 0; i < 20 && !m_busy; i++) step();
    chk("busy_seen", m_busy, 32'd1);
    rst = 1'b1;
    sbq.delete();
    step();
    chk_reset();
    set_op(0, 1'b0, 20'h00077, 16'h0000, 1);
    req[0] = 1'b1;
    expect_txn(0, 0);
    expect_txn(2, AC + 1);
    rst = 1'b0;
    wait_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 16-bit SRAM port between the audio engines (load, mix, pitch, record/play) that the control core starts. Each engine issues single-word read or write requests. The arbiter picks one requester at a time (round-robin, with optional fixed priority for requester 0), runs a fixed-length SRAM access, and returns an ack pulse plus read data. It sits between the engines and the top-level SRAM tri-state pads.

## Interface
- N_REQ, 4: number of requesters; index 0 is the real-time (record) port.
- ADDR_W, 20: SRAM word-address width.
- DATA_W, 16: SRAM data width.
- ACCESS_CYCLES, 2: cycles the SRAM signals are held per access (≥1).
- PRIO0, 0: 1 gives requester 0 fixed priority over round-robin.

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester request level.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  flattened; requester k at bits [k*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  flattened write data, same packing.
- ack  out  N_REQ  one-cycle pulse per completed access.
- grant  out  N_REQ  one-hot; identifies the requester owning the current access.
- rd_data  out  DATA_W  read data; valid in the ack cycle, held until the next read completes.
- busy  out  1  high while an access is in progress.
- sram_addr  out  ADDR_W
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_dq_out  out  DATA_W  write data to the pad.
- sram_dq_oe  out  1  pad output enable.
- sram_dq_in  in  DATA_W  pad read data.

## Operation
- All outputs are registered. Reset values: ack=0, grant=0, busy=0, rd_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1. The round-robin pointer resets to N_REQ-1, so requester 0 wins first.
- The FSM has two states: IDLE and ACCESS.
- **IDLE.** Compute the eligible set = req & ~ack, which excludes the requester being acked this cycle. If the set is empty, stay in IDLE. Otherwise pick a winner:
  - PRIO0=1 and requester 0 eligible: requester 0 wins.
  - Otherwise: the first eligible index after the pointer, wrapping N_REQ-1→0.
- **On a win:**
  - Register grant=one-hot(winner), busy=1, sram_ce_n=0.
  - Register sram_addr and sram_dq_out from the winner's slice.
  - Read: sram_oe_n=0. Write: sram_we_n=0 and sram_dq_oe=1.
  - Set pointer=winner and cnt=ACCESS_CYCLES-1. Go to ACCESS.
- **ACCESS.** Hold all SRAM outputs.
  - If cnt≠0, decrement cnt.
  - If cnt==0: for a read, rd_data<=sram_dq_in. Pulse the granted ack bit for one cycle. Return all strobes, grant and busy to their reset values (sram_addr and sram_dq_out hold). Go to IDLE.
- Request inputs are sampled only in IDLE at the win. Changes to req, addr, data or we during ACCESS are ignored, and an access is never aborted.
- Requesters hold req plus operands until they see ack. In the ack cycle a requester either drops req or presents its next operands.
- Requester 0 with PRIO0=1 cannot starve the others: it is excluded in its own ack cycle.

## Timing
- Request sampled in IDLE at cycle T:
  - SRAM driven and grant/busy high in cycles T+1 … T+ACCESS_CYCLES.
  - Read data sampled at the end of T+ACCESS_CYCLES.
  - ack and rd_data valid in cycle T+ACCESS_CYCLES+1.
- The ack cycle is an IDLE cycle, so a different eligible requester is granted in that same cycle. Sustained throughput is one access per ACCESS_CYCLES+1 cycles.
- Back-to-back accesses by the same requester with no competition: one extra idle cycle, period ACCESS_CYCLES+2.
- i_rst asserted mid-ACCESS: the next cycle shows reset values, and no ack is ever issued for the aborted access. Reset takes precedence over every transition.

## Test plan
- **Single read.** ACCESS_CYCLES=2. Req[1] with addr 0x00123 sampled at cycle T; sram_dq_in=0xBEEF.
  - Required: grant=0010, oe_n=0, ce_n=0, sram_addr=0x00123 in T+1..T+2.
  - ack=0010 and rd_data=0xBEEF in T+3. All strobes high in T+3.
- **Single write.** Req[2], we=1, addr 0x0ABCD, wdata 0x1234.
  - Required: we_n=0, dq_oe=1, dq_out=0x1234 for exactly 2 cycles; oe_n stays 1.
  - ack[2] pulses once. rd_data is unchanged.
- **Round-robin, PRIO0=0.** All four req held high from reset.
  - Required: grant order 0,1,2,3,0,1… with an ack every 3 cycles.
  - No requester is granted twice in a row.
- **Fixed priority, PRIO0=1.** Req[0] and req[2] held high.
  - Required: grant sequence 0,2,0,2…; requesters 1 and 3 never granted.
- **Operand change during ACCESS.** Req[3] addr changes 0x00010→0x00020 during ACCESS and req drops.
  - Required: sram_addr stays 0x00010; ack[3] still pulses; no new grant follows.
- **Reset mid-access.** i_rst pulsed in the first ACCESS cycle of a write.
  - Required: next cycle shows all reset values; no ack.
  - After release, the first grant goes to requester 0 if it is requesting.
